s_to_t_rr_sched: RTL and testbench
==================================

// Module: s_to_t_rr_sched
// PURPOSE
//  Shares one sign-magnitude -> two's-complement conversion stage among
//  N_REQ message producers (check/variable node units) of the LDPC decoder.
//  Round-robin arbitration picks at most one request per cycle, converts it,
//  and returns the result in a registered output slot tagged with the source
//  index. Sits between the node units and the two's-complement adder tree.
// PARAMETERS
//  W      5  message width; bit W-1 = sign, bits W-2:0 = magnitude
//  N_REQ  4  number of requesters (>=2)
//  TAG_W  2  width of out_tag, = clog2(N_REQ)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          async active-low reset
//  req_valid  in   N_REQ      per-requester request valid
//  req_data   in   N_REQ*W    packed sign-magnitude inputs, slot i = [i*W +: W]
//  req_ready  out  N_REQ      one-hot grant; request i accepted when valid&ready
//  out_valid  out  1          result slot holds valid data
//  out_ready  in   1          downstream accepts result
//  out_data   out  W          two's-complement result
//  out_tag    out  TAG_W      index of requester that produced out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_tag=0,
//    rr pointer=0; req_ready is 0 while rst_n is low.
//  - Slot free = !out_valid | out_ready. req_ready is combinational: 0 when the
//    slot is not free; otherwise one-hot to the first valid requester at or
//    after the rr pointer, wrapping N_REQ-1 -> 0. No valid request -> all 0.
//  - Accepted request is loaded into the slot at the next edge: latency 1 cycle
//    from accept to out_valid=1. Full throughput: 1 result/cycle when
//    out_ready stays high.
//  - Conversion: sign=0 -> out=mag; sign=1 -> out = -mag (two's complement,
//    W bits). Negative zero (1 followed by zeros) -> all zeros. Magnitude range
//    fits W bits, so no overflow/saturation.
//  - out_valid=1 & out_ready=0: slot and its outputs hold stable, no grant.
//  - Simultaneous drain and accept: slot reloads with new result,
//    out_valid stays 1.
//  - Drain with no new accept: out_valid->0; out_data/out_tag hold last values.
//  - rr pointer updates only on an accept: pointer = granted index + 1
//    (mod N_REQ). Unchanged on idle or stall cycles.
//  - req_data of a non-granted requester is ignored; requesters hold valid and
//    data until granted (no withdrawal).
//  - Reset mid-operation: pending slot content is discarded, pointer -> 0.
// CONFIGURATION
//  S2T_STATS_EN defined: adds outputs stat_conv[15:0] (accepted conversions)
//    and stat_stall[15:0] (cycles with any req_valid but no grant, i.e. slot
//    busy). Both saturate at 16'hFFFF and reset to 0.
//  Not defined: those ports and counters are absent; behaviour otherwise
//    identical.
// TESTING
//  1 Single requester 0, out_ready=1, data 10010,10101,11010,00100 ->
//    out_data 11110,11011,10110,00100, tag 0, each 1 cycle after accept.
//  2 Negative zero 10000 and zero 00000 -> 00000; 01111 -> 01111;
//    11111 -> 10001.
//  3 All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,...
//    one per cycle, tags match, no gaps.
//  4 out_ready=0 for 3 cycles with result pending -> out_data/out_tag stable,
//    req_ready=0; out_ready=1 -> drain and accept in same cycle.
//  5 Requesters 1 and 3 valid, pointer at 2 -> grant 3 first, then 1
//    (wrap-around); pointer ends at 2.
//  6 Assert rst_n=0 with out_valid=1 mid-burst -> out_valid drops
//    immediately; after release first grant goes to requester 0.
//  (S2T_STATS_EN) after test 3 for 10 cycles, stat_conv=10;
//    in test 4, stat_stall counts 3.

Source files
------------

// File: rtl/s_to_t_rr_sched_if.sv
// s_to_t_rr_sched_if: request/result handshake bundle between node units, the shared converter and the adder tree.
interface s_to_t_rr_sched_if #(
  parameter int W     = 5,
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [TAG_W-1:0]   out_tag;
  modport master (output req_valid, req_data, out_ready, input req_ready, out_valid, out_data, out_tag);
  modport slave  (input req_valid, req_data, out_ready, output req_ready, out_valid, out_data, out_tag);
endinterface

// File: rtl/s_to_t_rr_sched.sv
// s_to_t_rr_sched: round-robin shared sign-magnitude to two's-complement converter with a tagged result slot.
// Optional S2T_STATS_EN adds saturating conversion/stall counters.
module s_to_t_rr_sched #(
  parameter int W     = 5,
  parameter int N_REQ = 4,
  parameter int TAG_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef S2T_STATS_EN
  output logic [15:0]         stat_conv,
  output logic [15:0]         stat_stall,
`endif
  s_to_t_rr_sched_if.slave    bus
);
  logic [TAG_W-1:0] r_ptr;
  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [TAG_W-1:0] r_tag;
  logic             w_free;
  logic             w_found;
  logic [TAG_W-1:0] w_gidx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_acc;
  logic [W-1:0]     w_sel;
  logic [W-1:0]     w_mag;
  logic [W-1:0]     w_conv;
  assign w_free = !r_valid || bus.out_ready;
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_gidx  = TAG_W'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end
  // Grant is suppressed during reset so no requester sees a phantom accept.
  assign w_gnt  = (w_found && w_free && rst_n) ? (N_REQ'(1) << w_gidx) : '0;
  assign w_acc  = |w_gnt;
  assign w_sel  = bus.req_data[int'(w_gidx)*W +: W];
  assign w_mag  = {1'b0, w_sel[W-2:0]};
  assign w_conv = w_sel[W-1] ? (~w_mag + W'(1)) : w_mag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (w_acc) begin
      r_ptr   <= (w_gidx == TAG_W'(N_REQ-1)) ? '0 : w_gidx + TAG_W'(1);
      r_valid <= 1'b1;
      r_data  <= w_conv;
      r_tag   <= w_gidx;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
`ifdef S2T_STATS_EN
  logic [15:0] r_stat_conv;
  logic [15:0] r_stat_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_conv  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_acc && r_stat_conv != 16'hFFFF) r_stat_conv <= r_stat_conv + 16'd1;
      if (|bus.req_valid && !w_acc && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end
  assign stat_conv  = r_stat_conv;
  assign stat_stall = r_stat_stall;
`endif
  assign bus.req_ready = w_gnt;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_tag   = r_tag;
endmodule

// File: tb/tb_s_to_t_rr_sched.sv
// tb_s_to_t_rr_sched: directed table-driven bench for the round-robin sign-magnitude converter.
module tb_s_to_t_rr_sched;
  typedef struct {
    logic [3:0]  v;
    logic [19:0] d;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [4:0]  e_od;
    logic [1:0]  e_tag;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  s_to_t_rr_sched_if #(.W(5), .N_REQ(4), .TAG_W(2)) bus();
`ifdef S2T_STATS_EN
  logic [15:0] stat_conv;
  logic [15:0] stat_stall;
  s_to_t_rr_sched #(.W(5), .N_REQ(4), .TAG_W(2)) dut (.clk(clk), .rst_n(rst_n), .stat_conv(stat_conv), .stat_stall(stat_stall), .bus(bus));
`else
  s_to_t_rr_sched #(.W(5), .N_REQ(4), .TAG_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [3:0] v, input logic [4:0] d3, d2, d1, d0, input logic ordy,
                              input logic [3:0] e_rdy, input logic e_ov, input logic [4:0] e_od, input logic [1:0] e_tag);
    vec_t t;
    t.v = v; t.d = {d3, d2, d1, d0}; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_od = e_od; t.e_tag = e_tag;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t t, input int n);
    bus.req_valid = t.v; bus.req_data = t.d; bus.out_ready = t.ordy;
    #1;
    chk($sformatf("v%0d req_ready", n), 32'(bus.req_ready), 32'(t.e_rdy));
    @(posedge clk); #1;
    chk($sformatf("v%0d out_valid", n), 32'(bus.out_valid), 32'(t.e_ov));
    chk($sformatf("v%0d out_data", n), 32'(bus.out_data), 32'(t.e_od));
    chk($sformatf("v%0d out_tag", n), 32'(bus.out_tag), 32'(t.e_tag));
  endtask
  initial begin
    int n_acc, n_stall;
    // single requester 0 with conversions, then zero/extreme magnitudes
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b10010, 1, 4'b0001, 1, 5'b11110, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b10101, 1, 4'b0001, 1, 5'b11011, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b11010, 1, 4'b0001, 1, 5'b10110, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b00100, 1, 4'b0001, 1, 5'b00100, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b10000, 1, 4'b0001, 1, 5'b00000, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b01111, 1, 4'b0001, 1, 5'b01111, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b11111, 1, 4'b0001, 1, 5'b10001, 0));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b00000, 1, 4'b0001, 1, 5'b00000, 0));
    tbl.push_back(mk(4'b0000, 5'b0, 5'b0, 5'b0, 5'b00000, 1, 4'b0000, 0, 5'b00000, 0));
    // requester 3 alone moves the pointer to 0
    tbl.push_back(mk(4'b1000, 5'b00100, 5'b0, 5'b0, 5'b0, 1, 4'b1000, 1, 5'b00100, 3));
    // all four valid: 0,1,2,3,0,1
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0001, 1, 5'b00001, 0));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0010, 1, 5'b00010, 1));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0100, 1, 5'b11101, 2));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b1000, 1, 5'b00100, 3));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0001, 1, 5'b00001, 0));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0010, 1, 5'b00010, 1));
    // pointer at 2 with requesters 1 and 3: 3 then wrap to 1, pointer back at 2
    tbl.push_back(mk(4'b1010, 5'b00100, 5'b0, 5'b00010, 5'b0, 1, 4'b1000, 1, 5'b00100, 3));
    tbl.push_back(mk(4'b0010, 5'b0, 5'b0, 5'b00010, 5'b0, 1, 4'b0010, 1, 5'b00010, 1));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0100, 1, 5'b11101, 2));
    // stall three cycles, then drain+accept together
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 0, 4'b0000, 1, 5'b11101, 2));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 0, 4'b0000, 1, 5'b11101, 2));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 0, 4'b0000, 1, 5'b11101, 2));
    tbl.push_back(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b1000, 1, 5'b00100, 3));
    // drain without accept holds data/tag; empty slot is free even with out_ready low
    tbl.push_back(mk(4'b0000, 5'b0, 5'b0, 5'b0, 5'b0, 1, 4'b0000, 0, 5'b00100, 3));
    tbl.push_back(mk(4'b0000, 5'b0, 5'b0, 5'b0, 5'b0, 0, 4'b0000, 0, 5'b00100, 3));
    tbl.push_back(mk(4'b0001, 5'b0, 5'b0, 5'b0, 5'b00001, 0, 4'b0001, 1, 5'b00001, 0));
    bus.req_valid = 4'b1111; bus.req_data = '1; bus.out_ready = 1'b1;
    #12;
    chk("reset req_ready", 32'(bus.req_ready), 32'h0);
    chk("reset out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset out_data", 32'(bus.out_data), 32'h0);
    chk("reset out_tag", 32'(bus.out_tag), 32'h0);
    bus.req_valid = '0; bus.req_data = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_acc = 0; n_stall = 0;
    foreach (tbl[i]) begin
      run(tbl[i], i);
      if (tbl[i].e_rdy != 0) n_acc++;
      else if (tbl[i].v != 0) n_stall++;
    end
`ifdef S2T_STATS_EN
    chk("stat_conv", 32'(stat_conv), 32'(n_acc));
    chk("stat_stall", 32'(stat_stall), 32'(n_stall));
`endif
    // reset mid-burst with a pending result
    run(mk(4'b1111, 5'b00100, 5'b10011, 5'b00010, 5'b00001, 1, 4'b0010, 1, 5'b00010, 1), 100);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst req_ready", 32'(bus.req_ready), 32'h0);
    chk("midrst out_tag", 32'(bus.out_tag), 32'h0);
`ifdef S2T_STATS_EN
    chk("midrst stat_conv", 32'(stat_conv), 32'h0);
`endif
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post-rst req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    chk("post-rst out_valid", 32'(bus.out_valid), 32'h1);
    chk("post-rst out_tag", 32'(bus.out_tag), 32'h0);
    chk("post-rst out_data", 32'(bus.out_data), 32'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
